mux_n_1_stream: RTL
===================

Name: mux_n_1_stream

Overview:
- Parametrised N-input, WIDTH-bit multiplexer with valid/ready handshake, packet locking and a registered output stage.
- Successor to the single-bit 2:1 gate-level mux: it generalises channel count and width, adds round-robin arbitration mode, and adds back-pressure.
- Sits between N producer streams and one consumer. It guarantees that a packet is never interleaved with another channel's data.

Parameters:
N, 4, number of input channels (>=2)
WIDTH, 8, data width per channel
MODE, 0, 0 = external select (sel sampled at packet start); 1 = round-robin arbitration (sel ignored)
SW, $clog2(N), select/channel-index width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
sel  input  SW  channel select, used only when MODE=0
in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N  per-channel beat valid
in_last  input  N  per-channel end-of-packet flag, qualified by in_valid
in_ready  output  N  per-channel accept; combinational
out_data  output  WIDTH  registered data
out_valid  output  1  registered valid
out_last  output  1  registered end-of-packet
out_chan  output  SW  registered source channel of the current out beat
out_ready  input  1  consumer accept

Behaviour:
- Reset (asynchronous, active-high) sets the following:
  - out_valid=0, out_data=0, out_last=0, out_chan=0.
  - state=IDLE, lock=0.
  - rr_ptr=N-1, so channel 0 has top priority for the first grant.
- Output register space: space = !out_valid || out_ready. A beat transfers on an input when in_valid[i] && in_ready[i]. It transfers on the output when out_valid && out_ready.
- States:
  - IDLE: no packet in progress.
  - PKT: channel lock owns the output until its last beat.
- IDLE candidate selection:
  - MODE=0: cand=sel. If sel>=N, there is no candidate and all in_ready=0.
  - MODE=1: cand = first i with in_valid[i]=1, searching rr_ptr+1, rr_ptr+2, … with wrap modulo N.
  - No valid candidate: all in_ready=0.
- in_ready[i]=1 only when all of the following hold: space=1, and i==cand (IDLE) or i==lock (PKT). All other channels see 0. in_ready never depends on in_valid of the same channel in MODE=0.
- Accepted beat in IDLE:
  - Load out_data, out_last and out_chan=cand, and set out_valid=1 on the same edge.
  - If in_last=0: go to PKT with lock=cand.
  - If in_last=1 (single-beat packet): stay in IDLE.
  - MODE=1: rr_ptr=cand.
- Accepted beat in PKT:
  - Only channel lock is served; sel changes and other valids are ignored.
  - On an accepted beat with in_last=1: return to IDLE and set rr_ptr=lock.
- Output drain: if out_valid && out_ready and no new beat is accepted, out_valid goes to 0 on the next edge. out_data, out_last and out_chan hold their values when no load occurs.
- Latency and throughput: one cycle from input acceptance to out_valid. Full throughput is one beat per clock while out_ready=1. Simultaneous drain and load on the same edge keeps out_valid=1.
- Back-pressure: while out_valid=1 and out_ready=0, all in_ready=0 and the output register is stable.
- Round-robin fairness: the owning channel after a packet has lowest priority for the next grant.
- Reset mid-packet: lock is abandoned, state returns to IDLE, and any in-flight output beat is discarded (out_valid=0).
- MODE=0 sel changes while in IDLE take effect immediately, combinationally, on in_ready.

Test Plan:
- Reset/idle: assert rst mid-stream with out_valid=1 → outputs go to 0 immediately without a clock edge. After release with all in_valid=0 → in_ready=0, out_valid=0.
- MODE=0 packet lock: sel=2, ch2 sends 3 beats 0xA1, 0xA2, 0xA3 (last on the 3rd), and sel switches to 1 after beat 1 with ch1 valid.
  - Required: out_data is 0xA1, 0xA2, 0xA3 in consecutive cycles with out_chan=2.
  - Required: in_ready[1]=0 until after 0xA3, then ch1 is served.
- MODE=1 round-robin: ch0, ch1 and ch3 each hold single-beat packets 0x10, 0x11, 0x13 continuously valid → output order is ch0, ch1, ch3, ch0, …; ch2 is never granted.
- Back-pressure: hold out_ready=0 for 3 cycles with a beat 0x55 in the output register.
  - Required: out_data=0x55 stable and all in_ready=0.
  - On release: the next beat appears on the cycle after with no loss or duplication.
- Full throughput: a 5-beat packet with out_ready=1 → 5 consecutive out_valid cycles, out_last only on the 5th, then the next grant decision follows immediately.
- Out-of-range sel: N=3, MODE=0, sel=3 → all in_ready=0 and out_valid stays 0. Changing sel to 0 with ch0 valid → accepted on that edge.

Source files
------------

// File: rtl/mux_n_1_stream.sv
// N:1 stream multiplexer with valid/ready handshake, packet locking and a registered output.
// Select is either an external channel index (MODE=0) or round-robin over valid channels (MODE=1).

module mux_n_1_stream_lane #(
  parameter int SW  = 2,
  parameter int IDX = 0
) (
  input  logic          grant_en,
  input  logic [SW-1:0] owner,
  input  logic          valid,
  output logic          ready,
  output logic          hs
);
  assign ready = grant_en && (owner == SW'(IDX));
  assign hs    = ready && valid;
endmodule

module mux_n_1_stream #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int SW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]     in_valid,
  input  logic [N-1:0]     in_last,
  output logic [N-1:0]     in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic [SW-1:0]    out_chan,
  input  logic             out_ready
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PKT  = 1'b1;

  logic [0:0]       state;
  logic [SW-1:0]    lock, rr_ptr, cand, owner;
  logic             cand_ok, owner_ok, space, grant_en, take, take_last;
  logic [N-1:0]     hs;
  logic [WIDTH-1:0] take_data;

  assign space = !out_valid || out_ready;

  // Round-robin scans from the farthest channel back so the nearest valid one after rr_ptr wins.
  always_comb begin
    cand    = '0;
    cand_ok = 1'b0;
    if (MODE == 0) begin
      cand    = sel;
      cand_ok = (int'(sel) < N);
    end else begin
      for (int k = N; k >= 1; k--) begin
        if (in_valid[(int'(rr_ptr) + k) % N]) begin
          cand    = SW'((int'(rr_ptr) + k) % N);
          cand_ok = 1'b1;
        end
      end
    end
  end

  assign owner    = (state == PKT) ? lock : cand;
  assign owner_ok = (state == PKT) || cand_ok;
  assign grant_en = space && owner_ok;

  for (genvar i = 0; i < N; i++) begin : g_lane
    mux_n_1_stream_lane #(.SW(SW), .IDX(i)) u_lane (
      .grant_en (grant_en),
      .owner    (owner),
      .valid    (in_valid[i]),
      .ready    (in_ready[i]),
      .hs       (hs[i])
    );
  end

  assign take      = |hs;
  assign take_last = |(hs & in_last);

  always_comb begin
    take_data = '0;
    for (int i = 0; i < N; i++)
      if (hs[i]) take_data = take_data | in_data[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
      state     <= IDLE;
      lock      <= '0;
      rr_ptr    <= SW'(N-1);
    end else begin
      if (take) begin
        out_valid <= 1'b1;
        out_data  <= take_data;
        out_last  <= take_last;
        out_chan  <= owner;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (take) begin
        if (state == IDLE) begin
          if (!take_last) begin
            state <= PKT;
            lock  <= cand;
          end
          if (MODE == 1) rr_ptr <= cand;
        end else if (take_last) begin
          state  <= IDLE;
          rr_ptr <= lock;
        end
      end
    end
  end
endmodule
